// File: rtl/fprint_comparator.sv
// Fingerprint comparator: round-robin picks a task whose two core fingerprints are ready,
// reads both from the CRC RAM, compares them and runs the tail-advance or task-reset handshake.
module fprint_comparator #(
  parameter int CRC_RAM_ADDRESS_WIDTH = 8,
  parameter int CRC_KEY_WIDTH         = 4,
  parameter int CRC_KEY_SIZE          = 16,
  parameter int FPRINT_WIDTH          = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             comp_enable,
  input  logic [CRC_KEY_SIZE-1:0]          fprints_ready_in,
  input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer0,
  input  logic [CRC_RAM_ADDRESS_WIDTH-1:0] comp_tail_pointer1,
  output logic [CRC_KEY_WIDTH-1:0]         comp_task,
  output logic                             comp_increment_tail_pointer,
  output logic                             comp_reset_fprint_ready,
  input  logic                             reset_fprint_ack,
  output logic                             comp_reset_task,
  input  logic                             reset_task,
  output logic                             comp_mismatch_detected,
  output logic [CRC_KEY_WIDTH-1:0]         mismatch_task,
  output logic                             mismatch_irq,
  input  logic                             mismatch_clear,
  output logic                             ram_rd,
  output logic [CRC_RAM_ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [FPRINT_WIDTH-1:0]          ram_rdata,
  output logic [15:0]                      match_count
);

  localparam int AW = CRC_RAM_ADDRESS_WIDTH;
  localparam int KW = CRC_KEY_WIDTH;
  localparam int KS = CRC_KEY_SIZE;

  typedef enum logic [3:0] {
    IDLE, WAIT_PTR, READ0, READ1, COMPARE, WAIT_INC, REQ_CLEAR, SETTLE, REQ_RESET, HOLD
  } state_t;

  state_t              state, state_next;
  logic [KW-1:0]       rr_ptr;
  logic [FPRINT_WIDTH-1:0] fp0;
  logic [AW-1:0]       addr_q;
  logic [KW-1:0]       sel_task;
  logic                sel_valid;
  logic                fp_equal;

  // Circular search from rr_ptr; the index wraps naturally because KS == 2**KW.
  always_comb begin
    sel_task  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < KS; i++) begin
      if (!sel_valid && fprints_ready_in[rr_ptr + KW'(i)]) begin
        sel_valid = 1'b1;
        sel_task  = rr_ptr + KW'(i);
      end
    end
  end

  assign fp_equal = (fp0 == ram_rdata);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next                  = state;
    ram_rd                      = 1'b0;
    ram_addr                    = addr_q;
    comp_increment_tail_pointer = 1'b0;
    comp_reset_fprint_ready     = 1'b0;
    comp_reset_task             = 1'b0;
    mismatch_irq                = 1'b0;
    case (state)
      IDLE:      if (comp_enable && sel_valid) state_next = WAIT_PTR;
      WAIT_PTR:  state_next = READ0;
      READ0: begin
        ram_rd     = 1'b1;
        ram_addr   = comp_tail_pointer0;
        state_next = READ1;
      end
      READ1: begin
        ram_rd     = 1'b1;
        ram_addr   = comp_tail_pointer1;
        state_next = COMPARE;
      end
      COMPARE: begin
        if (fp_equal) begin
          comp_increment_tail_pointer = 1'b1;
          state_next                  = WAIT_INC;
        end else begin
          mismatch_irq = 1'b1;
          state_next   = REQ_RESET;
        end
      end
      WAIT_INC:  state_next = REQ_CLEAR;
      REQ_CLEAR: begin
        comp_reset_fprint_ready = 1'b1;
        if (reset_fprint_ack) state_next = SETTLE;
      end
      // One dead cycle so the ready flag we just cleared has propagated before IDLE samples it.
      SETTLE:    state_next = IDLE;
      REQ_RESET: begin
        comp_reset_task = 1'b1;
        if (reset_task) state_next = HOLD;
      end
      HOLD:      if (mismatch_clear) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      comp_task              <= '0;
      rr_ptr                 <= '0;
      fp0                    <= '0;
      addr_q                 <= '0;
      match_count            <= '0;
      comp_mismatch_detected <= 1'b0;
      mismatch_task          <= '0;
    end else begin
      if (state == IDLE && comp_enable && sel_valid) begin
        comp_task <= sel_task;
        rr_ptr    <= sel_task + KW'(1);
      end
      if (ram_rd) addr_q <= ram_addr;
      // Data for the READ0 address arrives during READ1.
      if (state == READ1) fp0 <= ram_rdata;
      if (state == COMPARE) begin
        if (fp_equal) begin
          match_count <= match_count + 16'd1;
        end else begin
          comp_mismatch_detected <= 1'b1;
          mismatch_task          <= comp_task;
        end
      end
      if (state == HOLD && mismatch_clear) comp_mismatch_detected <= 1'b0;
    end
  end

endmodule

// File: doc/fprint_comparator.md
FPRINT_COMPARATOR -- requirements
Module: fprint_comparator

Interface
REQ-001 The block SHALL take widths CRC_RAM_ADDRESS_WIDTH (AW), CRC_KEY_WIDTH (KW, 4) and CRC_KEY_SIZE (KS, 16) from crc_defines.v.
REQ-002 Parameter FPRINT_WIDTH, default 32, SHALL be the fingerprint word width in the CRC RAM.
REQ-003 Ports SHALL be:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- comp_enable  in  1  when 0, no new comparison starts
- fprints_ready_in  in  KS  per-task "both cores have fingerprints" flags
- comp_tail_pointer0  in  AW  core-0 tail for comp_task, registered one clk after comp_task
- comp_tail_pointer1  in  AW  core-1 tail for comp_task, registered one clk after comp_task
- comp_task  out  KW  task being compared
- comp_increment_tail_pointer  out  1  one-cycle pulse, advance both tails
- comp_reset_fprint_ready  out  1  level request
- reset_fprint_ack  in  1  one-cycle ack
- comp_reset_task  out  1  level request
- reset_task  in  1  one-cycle ack
- comp_mismatch_detected  out  1  sticky mismatch flag
- mismatch_task  out  KW  task that mismatched
- mismatch_irq  out  1  one-cycle pulse
- mismatch_clear  in  1  processor release
- ram_rd  out  1  CRC RAM read strobe
- ram_addr  out  AW  CRC RAM address
- ram_rdata  in  FPRINT_WIDTH  data, valid the cycle after ram_rd
- match_count  out  16  successful compares, wraps 0xFFFF->0

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_PTR, READ0, READ1, COMPARE, WAIT_INC, REQ_CLEAR, SETTLE, REQ_RESET, HOLD.
REQ-005 In IDLE with comp_enable=1, it SHALL pick the lowest set bit of fprints_ready_in at or above (rr_ptr) circularly, register it into comp_task, set rr_ptr=task+1 mod KS, and go to WAIT_PTR; with no bit set or comp_enable=0, it SHALL remain in IDLE.
REQ-006 WAIT_PTR SHALL last exactly one cycle so that tail pointers reflect the new comp_task.
REQ-007 In READ0, ram_rd=1 and ram_addr=comp_tail_pointer0; in READ1, ram_rd=1 and ram_addr=comp_tail_pointer1, and the block SHALL capture ram_rdata as fp0 at the end of READ1.
REQ-008 In COMPARE, the block SHALL compare fp0 with ram_rdata (fp1) over all FPRINT_WIDTH bits.
REQ-009 On equality, the block SHALL assert comp_increment_tail_pointer for exactly the COMPARE cycle, increment match_count, and go to WAIT_INC (one cycle), then REQ_CLEAR.
REQ-010 In REQ_CLEAR, comp_reset_fprint_ready SHALL be 1 (Moore output); on reset_fprint_ack=1, the block SHALL go to SETTLE, dropping the request the next cycle.
REQ-011 SETTLE SHALL last one cycle and then return to IDLE, so that stale fprints_ready_in is never sampled.
REQ-012 On inequality, the block SHALL set comp_mismatch_detected=1, latch mismatch_task=comp_task, pulse mismatch_irq for one cycle, and go to REQ_RESET; comp_increment_tail_pointer SHALL stay 0.
REQ-013 In REQ_RESET, comp_reset_task SHALL be 1 (Moore); on reset_task=1, the block SHALL go to HOLD.
REQ-014 In HOLD, the block SHALL wait for mismatch_clear=1, then clear comp_mismatch_detected and return to IDLE; mismatch_task SHALL retain its value until the next mismatch.
REQ-015 The block SHALL ignore acks that arrive outside REQ_CLEAR/REQ_RESET, and mismatch_clear outside HOLD.
REQ-016 The block SHALL never assert more than one of comp_increment_tail_pointer, comp_reset_fprint_ready and comp_reset_task in the same cycle.
REQ-017 A comp_enable drop mid-sequence SHALL NOT abort the sequence; it SHALL only block the next IDLE selection.
REQ-018 ram_rd SHALL be 0 in all states other than READ0/READ1; ram_addr SHALL hold its last value.

Reset
REQ-019 On a clk edge with reset=1, the block SHALL enter IDLE with all outputs 0, comp_task=0, rr_ptr=0, mismatch_task=0, match_count=0 and fp0=0.
REQ-020 Reset SHALL take effect in any state, including an outstanding request, and SHALL drop that request on the next cycle.

Verification
REQ-021 fprints_ready_in=0x0004, tails 0x10/0x20, RAM holds 0xCAFEBABE at both -> comp_task=2, reads at 0x10 then 0x20, one increment pulse, request held until ack, match_count=1, back in IDLE.
REQ-022 fprints_ready_in=0x8001 held, rr_ptr=0 -> tasks are serviced in order 0, 15, 0, 15 (round-robin).
REQ-023 Data 0x12345678 vs 0x12345679 on task 5 -> mismatch_irq one pulse, comp_mismatch_detected=1, mismatch_task=5, comp_reset_task held until reset_task, no increment, stays in HOLD until mismatch_clear.
REQ-024 reset_fprint_ack delayed 7 cycles -> comp_reset_fprint_ready high for exactly 7 cycles plus the ack cycle; no new task selected before SETTLE completes.
REQ-025 reset asserted in REQ_RESET -> next cycle all outputs 0, state IDLE; a stray reset_task afterwards has no effect.
REQ-026 comp_enable=0 with fprints_ready_in=0xFFFF -> no ram_rd for 100 cycles; comp_enable=1 -> task 0 selected the next cycle.
